// File: rtl/rst_cypher_pkg.sv
// rst_cypher_pkg
//   Shared definitions for the rotation-table loader:
//   - printable key character ranges (digits, upper case, lower case)
//   - NUL_CHAR, the value returned for the corner cell and for blocked reads
//   - body alphabet length (26 letters followed by 10 digits)
//   - loader state enum
//   - body_char(): maps a body alphabet index to its character
package rst_cypher_pkg;

  localparam logic [7:0] NUL_CHAR = 8'h00;

  localparam logic [7:0] DIGIT_LO = 8'h30;
  localparam logic [7:0] DIGIT_HI = 8'h39;
  localparam logic [7:0] UPPER_LO = 8'h41;
  localparam logic [7:0] UPPER_HI = 8'h5A;
  localparam logic [7:0] LOWER_LO = 8'h61;
  localparam logic [7:0] LOWER_HI = 8'h7A;

  localparam int BODY_ALPHA_LEN = 36;
  localparam int BODY_LETTERS   = 26;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FILL,
    DONE,
    ERROR
  } state_t;

  // Body alphabet: 'a'..'z' for indices 0..25, then '0'..'9' for 26..35.
  function automatic logic [7:0] body_char(input logic [5:0] idx);
    if (idx < 6'(BODY_LETTERS)) begin
      return LOWER_LO + {2'b00, idx};
    end
    return DIGIT_LO + ({2'b00, idx} - 8'(BODY_LETTERS));
  endfunction

endpackage

// File: rtl/rot_char_check.sv
// rot_char_check
//   Combinational classification of one key character against the set of
//   characters already seen in the current key.
//   Build option: ROT_TABLE_CASE_FOLD_EN -- when defined, letters are folded
//   to one bitmap slot per letter (bit 5 cleared), so 'a' repeats 'A'.
// Ports:
//   ch        in   8    candidate key character
//   seen      in   128  bitmap of characters already accepted
//   invalid   out  1    character is not a digit or ASCII letter
//   repeated  out  1    bitmap slot for this character is already set
//   bit_idx   out  7    bitmap slot this character maps to
module rot_char_check
  import rst_cypher_pkg::*;
(
  input  logic [7:0]   ch,
  input  logic [127:0] seen,
  output logic         invalid,
  output logic         repeated,
  output logic [6:0]   bit_idx
);

  logic is_digit;
  logic is_upper;
  logic is_lower;
  logic is_letter;

  assign is_digit  = (ch >= DIGIT_LO) && (ch <= DIGIT_HI);
  assign is_upper  = (ch >= UPPER_LO) && (ch <= UPPER_HI);
  assign is_lower  = (ch >= LOWER_LO) && (ch <= LOWER_HI);
  assign is_letter = is_upper || is_lower;

  assign invalid = !(is_digit || is_letter);

`ifdef ROT_TABLE_CASE_FOLD_EN
  // Upper and lower case differ only in bit 5.
  assign bit_idx = is_letter ? {ch[6], 1'b0, ch[4:0]} : ch[6:0];
`else
  assign bit_idx = ch[6:0];
`endif

  assign repeated = seen[bit_idx];

endmodule

// File: rtl/rot_table_loader.sv
// rot_table_loader
//   Loads a KEY_LEN-character key into the header row/column of a DIM x DIM
//   table, rejecting invalid or repeated characters, then fills the body
//   with the repeating alphabet a..z0..9 one cell per cycle.
//   Build option: ROT_TABLE_CASE_FOLD_EN -- case-insensitive repeat check.
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   start                 pulse; restarts a key load from any state
//   key_valid/key_char    key stream input, key index 0 first
//   key_ready             high only while loading the key
//   rd_row, rd_col        table read address
//   rd_data               registered read data (0x00 unless DONE and in range)
//   table_valid           table complete
//   err_repeated_char     sticky: a key character repeated an earlier one
//   err_invalid_key_char  sticky: a key character was not [0-9A-Za-z]
module rot_table_loader
  import rst_cypher_pkg::*;
#(
  parameter  int KEY_LEN = 12,
  localparam int N       = KEY_LEN / 2,
  localparam int DIM     = N + 1,
  localparam int AW      = $clog2(DIM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          key_valid,
  input  logic [7:0]    key_char,
  output logic          key_ready,
  input  logic [AW-1:0] rd_row,
  input  logic [AW-1:0] rd_col,
  output logic [7:0]    rd_data,
  output logic          table_valid,
  output logic          err_repeated_char,
  output logic          err_invalid_key_char
);

  localparam int MEM_DEPTH = DIM * DIM;
  localparam int MAW       = $clog2(MEM_DEPTH);
  localparam int KCW       = $clog2(KEY_LEN);

  state_t state_reg, state_next;

  logic [KCW-1:0] key_idx_reg;
  logic [AW-1:0]  fill_row_reg;
  logic [AW-1:0]  fill_col_reg;
  logic [5:0]     alpha_reg;
  logic           err_rep_reg;
  logic           err_inv_reg;
  logic           table_valid_reg;
  logic [127:0]   seen_reg;
  logic [127:0]   seen_set;

  logic [7:0]     mem [MEM_DEPTH];
  logic [7:0]     mem_q_reg;
  logic           rd_ok_reg;

  logic           accept;
  logic           good_accept;
  logic           char_invalid;
  logic           char_repeated;
  logic [6:0]     char_idx;
  logic           key_last;
  logic           cell_last;

  logic           wr_en;
  logic [MAW-1:0] wr_addr;
  logic [7:0]     wr_data;
  logic           rd_in_range;
  logic [MAW-1:0] rd_addr;

  // Header cell for key index k: chars 2q and 2q+1 form pair q, which lives
  // at header position p (odd positions take pairs from the front of the
  // key, even positions from the back). Even k goes down column 0, odd k
  // along row 0.
  function automatic logic [MAW-1:0] header_addr(input logic [KCW-1:0] k);
    int q;
    int p;
    q = int'(k) / 2;
    if (2 * q + 1 <= N) begin
      p = 2 * q + 1;
    end else begin
      p = 2 * (N - q);
    end
    if (k[0] == 1'b0) begin
      return MAW'(p * DIM);
    end
    return MAW'(p);
  endfunction

  rot_char_check u_char_check (
    .ch       (key_char),
    .seen     (seen_reg),
    .invalid  (char_invalid),
    .repeated (char_repeated),
    .bit_idx  (char_idx)
  );

  assign key_ready   = (state_reg == LOAD);
  // start wins over a char offered in the same cycle
  assign accept      = key_valid && key_ready && !start;
  assign good_accept = accept && !char_invalid && !char_repeated;
  assign key_last    = (key_idx_reg == KCW'(KEY_LEN - 1));
  assign cell_last   = (fill_row_reg == AW'(N)) && (fill_col_reg == AW'(N));

  // ---------------- state machine ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (start) begin
      state_next = LOAD;
    end else begin
      case (state_reg)
        LOAD: begin
          if (accept) begin
            if (char_invalid || char_repeated) begin
              state_next = ERROR;
            end else if (key_last) begin
              state_next = FILL;
            end
          end
        end
        FILL: begin
          if (cell_last) begin
            state_next = DONE;
          end
        end
        default: begin
          state_next = state_reg;
        end
      endcase
    end
  end

  // ---------------- error flags ----------------
  always_ff @(posedge clk) begin
    if (rst || start) begin
      err_inv_reg <= 1'b0;
      err_rep_reg <= 1'b0;
    end else if (accept) begin
      // an invalid char never also reports as a repeat
      if (char_invalid) begin
        err_inv_reg <= 1'b1;
      end else if (char_repeated) begin
        err_rep_reg <= 1'b1;
      end
    end
  end

  // ---------------- seen bitmap ----------------
  for (genvar gi = 0; gi < 128; gi++) begin : g_seen
    assign seen_set[gi] = good_accept && (char_idx == 7'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      seen_reg <= '0;
    end else begin
      seen_reg <= seen_reg | seen_set;
    end
  end

  // ---------------- counters ----------------
  always_ff @(posedge clk) begin
    if (rst || start) begin
      key_idx_reg  <= '0;
      fill_row_reg <= AW'(1);
      fill_col_reg <= AW'(1);
      alpha_reg    <= '0;
    end else begin
      if (good_accept) begin
        key_idx_reg <= key_idx_reg + 1'b1;
      end
      if (state_reg == FILL) begin
        if (fill_col_reg == AW'(N)) begin
          fill_col_reg <= AW'(1);
          fill_row_reg <= fill_row_reg + 1'b1;
        end else begin
          fill_col_reg <= fill_col_reg + 1'b1;
        end
        // running cell index modulo the body alphabet length
        alpha_reg <= (alpha_reg == 6'(BODY_ALPHA_LEN - 1)) ? 6'd0 : alpha_reg + 6'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      table_valid_reg <= 1'b0;
    end else begin
      table_valid_reg <= (state_reg == DONE);
    end
  end

  // ---------------- table memory ----------------
  // Header cells are written as chars are accepted, body cells during FILL.
  // Cell (0,0) is never written; reads of it are forced to NUL_CHAR.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = key_char;
    if (good_accept) begin
      wr_en   = 1'b1;
      wr_addr = header_addr(key_idx_reg);
    end else if (state_reg == FILL) begin
      wr_en   = 1'b1;
      wr_addr = MAW'(int'(fill_row_reg) * DIM + int'(fill_col_reg));
      wr_data = body_char(alpha_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_in_range = (int'(rd_row) < DIM) && (int'(rd_col) < DIM);
  assign rd_addr     = rd_in_range ? MAW'(int'(rd_row) * DIM + int'(rd_col)) : '0;

  always_ff @(posedge clk) begin
    mem_q_reg <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ok_reg <= 1'b0;
    end else begin
      rd_ok_reg <= (state_reg == DONE) && rd_in_range &&
                   !((rd_row == '0) && (rd_col == '0));
    end
  end

  assign rd_data              = rd_ok_reg ? mem_q_reg : NUL_CHAR;
  assign table_valid          = table_valid_reg;
  assign err_repeated_char    = err_rep_reg;
  assign err_invalid_key_char = err_inv_reg;

endmodule

// File: tb/tb_rot_table_loader.sv
// tb_rot_table_loader
//   Drives fixed and random keys into a KEY_LEN=12 loader and a fixed key
//   into a KEY_LEN=4 loader, predicting errors, table contents and timing
//   from a behavioural model of the key/table rules.
//   Honours ROT_TABLE_CASE_FOLD_EN in its model of repeat detection.
module tb_rot_table_loader;

  localparam int N    = 6;
  localparam int DIM  = 7;
  localparam int AW   = 3;
  localparam int N4   = 2;
  localparam int AW4  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start, key_valid, key_ready;
  logic [7:0]    key_char, rd_data;
  logic [AW-1:0] rd_row, rd_col;
  logic          table_valid, err_rep, err_inv;

  logic           start4, key_valid4, key_ready4;
  logic [7:0]     key_char4, rd_data4;
  logic [AW4-1:0] rd_row4, rd_col4;
  logic           table_valid4, err_rep4, err_inv4;

  rot_table_loader #(.KEY_LEN(12)) dut (
    .clk(clk), .rst(rst), .start(start), .key_valid(key_valid),
    .key_char(key_char), .key_ready(key_ready), .rd_row(rd_row),
    .rd_col(rd_col), .rd_data(rd_data), .table_valid(table_valid),
    .err_repeated_char(err_rep), .err_invalid_key_char(err_inv)
  );

  rot_table_loader #(.KEY_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .key_valid(key_valid4),
    .key_char(key_char4), .key_ready(key_ready4), .rd_row(rd_row4),
    .rd_col(rd_col4), .rd_data(rd_data4), .table_valid(table_valid4),
    .err_repeated_char(err_rep4), .err_invalid_key_char(err_inv4)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] cur_key[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_key_char(input logic [7:0] c);
    return (c >= "0" && c <= "9") || (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction

  // Index of the first offending char (-1 if none); kind 1 = invalid, 2 = repeat.
  function automatic int first_bad(input logic [7:0] k[$], output int kind);
    logic [7:0] prior[$];
    logic [7:0] c;
    kind = 0;
    for (int i = 0; i < k.size(); i++) begin
      if (!is_key_char(k[i])) begin
        kind = 1;
        return i;
      end
      c = k[i];
`ifdef ROT_TABLE_CASE_FOLD_EN
      if (c >= "a") c = c - 8'h20;
`endif
      foreach (prior[j]) begin
        if (prior[j] == c) begin
          kind = 2;
          return i;
        end
      end
      prior.push_back(c);
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_cell(input logic [7:0] k[$], input int n, input int r, input int c);
    int p, q, idx;
    if (r > n || c > n) return 8'h00;
    if (r == 0 && c == 0) return 8'h00;
    if (r == 0 || c == 0) begin
      p = (c == 0) ? r : c;
      q = (p % 2 == 1) ? (p - 1) / 2 : n - p / 2;
      return (c == 0) ? k[2*q] : k[2*q+1];
    end
    idx = ((r - 1) * n + (c - 1)) % 36;
    return (idx < 26) ? 8'(8'h61 + idx) : 8'(8'h30 + idx - 26);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_key(input string s);
    cur_key.delete();
    for (int i = 0; i < s.len(); i++) cur_key.push_back(s[i]);
  endtask

  function automatic logic [7:0] rand_key_char();
    int v;
    v = $urandom_range(0, 61);
    if (v < 10) return 8'(8'h30 + v);
    if (v < 36) return 8'(8'h41 + v - 10);
    return 8'(8'h61 + v - 36);
  endfunction

  function automatic logic [7:0] rand_bad_char();
    case ($urandom_range(0, 2))
      0:       return 8'($urandom_range(8'h00, 8'h2F));
      1:       return 8'($urandom_range(8'h5B, 8'h60));
      default: return 8'($urandom_range(8'h7B, 8'hFF));
    endcase
  endfunction

  // mode 0: distinct chars, 1: one invalid char, 2: one repeated char
  task automatic make_key(input int mode);
    logic [7:0] c;
    bit dup;
    int pos;
    cur_key.delete();
    while (cur_key.size() < 12) begin
      c = rand_key_char();
      dup = 0;
      foreach (cur_key[j]) if (cur_key[j] == c) dup = 1;
      if (!dup) cur_key.push_back(c);
    end
    if (mode == 1) begin
      pos = $urandom_range(0, 11);
      cur_key[pos] = rand_bad_char();
    end else if (mode == 2) begin
      pos = $urandom_range(1, 11);
      cur_key[pos] = cur_key[$urandom_range(0, pos - 1)];
    end
  endtask

  // Load cur_key into the 12-char loader and check the outcome.
  task automatic run_key(input string name);
    int kind, bad, last_i, cyc;
    bad = first_bad(cur_key, kind);
    // start with a junk char offered alongside: it must not be accepted
    @(negedge clk);
    start = 1'b1; key_valid = 1'b1; key_char = 8'h23;
    @(negedge clk);
    start = 1'b0; key_valid = 1'b0;
    check($sformatf("%s_start_flags", name), 32'({err_inv, err_rep}), 32'd0);
    check($sformatf("%s_start_tv", name), 32'(table_valid), 32'd0);
    last_i = (bad >= 0) ? bad : cur_key.size() - 1;
    for (int i = 0; i <= last_i; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      key_valid = 1'b1;
      key_char  = cur_key[i];
      check($sformatf("%s_ready%0d", name, i), 32'(key_ready), 32'd1);
      @(negedge clk);
      key_valid = 1'b0;
    end
    if (bad >= 0) begin
      check($sformatf("%s_err_flags", name), 32'({err_inv, err_rep}),
            (kind == 1) ? 32'd2 : 32'd1);
      check($sformatf("%s_err_ready", name), 32'(key_ready), 32'd0);
      key_valid = 1'b1; key_char = 8'h41;
      rd_row = 3'd1; rd_col = 3'd0;
      repeat (3) @(negedge clk);
      key_valid = 1'b0;
      check($sformatf("%s_err_hold", name), 32'({err_inv, err_rep}),
            (kind == 1) ? 32'd2 : 32'd1);
      check($sformatf("%s_err_tv", name), 32'(table_valid), 32'd0);
      check($sformatf("%s_err_rd", name), 32'(rd_data), 32'd0);
      $display("[TB] key %s rejected at index %0d (kind %0d)", name, bad, kind);
    end else begin
      check($sformatf("%s_ok_flags", name), 32'({err_inv, err_rep}), 32'd0);
      check($sformatf("%s_fill_ready", name), 32'(key_ready), 32'd0);
      cyc = 0;
      while (!table_valid && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      check($sformatf("%s_tv_latency", name), 32'(cyc), 32'(N * N + 1));
      for (int r = 0; r <= 7; r++) begin
        for (int c = 0; c <= 7; c++) begin
          rd_row = 3'(r); rd_col = 3'(c);
          @(negedge clk);
          check($sformatf("%s_rd_%0d_%0d", name, r, c), 32'(rd_data),
                32'(exp_cell(cur_key, N, r, c)));
        end
      end
      $display("[TB] key %s loaded, table_valid after %0d cycles", name, cyc);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] k4[$];
    int cyc;
    rst = 1'b1;
    start = 1'b0; key_valid = 1'b0; key_char = 8'h00; rd_row = '0; rd_col = '0;
    start4 = 1'b0; key_valid4 = 1'b0; key_char4 = 8'h00; rd_row4 = '0; rd_col4 = '0;
    rd_row = 3'd1; rd_col = 3'd1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_ready", 32'(key_ready), 32'd0);
    check("reset_tv", 32'(table_valid), 32'd0);
    check("reset_flags", 32'({err_inv, err_rep}), 32'd0);
    check("reset_rd", 32'(rd_data), 32'd0);

    set_key("ABCDEFGHIJKL");
    run_key("alpha");
    set_key("ABCDEAGHIJKL");
    run_key("rep6");
    set_key("AB#DEFGHIJKL");
    run_key("inv3");
    set_key("aBcDeAGHIJKL");
    run_key("case");

    // reset during FILL aborts; the loader waits in IDLE for a new start
    set_key("MNOPQRSTUVWX");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    foreach (cur_key[i]) begin
      key_valid = 1'b1; key_char = cur_key[i];
      @(negedge clk);
    end
    key_valid = 1'b0;
    rd_row = 3'd1; rd_col = 3'd0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstfill_ready", 32'(key_ready), 32'd0);
    check("rstfill_tv", 32'(table_valid), 32'd0);
    check("rstfill_flags", 32'({err_inv, err_rep}), 32'd0);
    check("rstfill_rd", 32'(rd_data), 32'd0);
    repeat (40) @(negedge clk);
    check("rstfill_idle_tv", 32'(table_valid), 32'd0);
    check("rstfill_idle_ready", 32'(key_ready), 32'd0);
    $display("[TB] reset during FILL");
    set_key("z9y8x7w6v5u4");
    run_key("after_rst");

    for (int t = 0; t < 9; t++) begin
      make_key(t % 3);
      run_key($sformatf("rnd%0d", t));
    end

    // KEY_LEN = 4 instance
    k4 = '{"W", "X", "Y", "Z"};
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    foreach (k4[i]) begin
      key_valid4 = 1'b1; key_char4 = k4[i];
      check($sformatf("k4_ready%0d", i), 32'(key_ready4), 32'd1);
      @(negedge clk);
    end
    key_valid4 = 1'b0;
    cyc = 0;
    while (!table_valid4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("k4_tv_latency", 32'(cyc), 32'(N4 * N4 + 1));
    check("k4_flags", 32'({err_inv4, err_rep4}), 32'd0);
    for (int r = 0; r <= 3; r++) begin
      for (int c = 0; c <= 3; c++) begin
        rd_row4 = 2'(r); rd_col4 = 2'(c);
        @(negedge clk);
        check($sformatf("k4_rd_%0d_%0d", r, c), 32'(rd_data4), 32'(exp_cell(k4, N4, r, c)));
      end
    end
    $display("[TB] key WXYZ loaded into KEY_LEN=4 table");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
